// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one block-wide main-memory port between the I-cache and D-cache
// controllers.
//
// Arbitration is round-robin. A grant is held until the transaction completes.
// While d_lock_i is high the D-cache keeps the grant across transactions.
// A watchdog drops the grant and raises a sticky flag if memory never answers.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   i_addr_i/i_wr_i      I-cache block address / write data
//   i_rw_i/i_valid_i     I-cache direction (1 = write) / level-held request
//   i_rd_o/i_ready_o     read data / one-cycle completion pulse to I-cache
//   d_addr_i/d_wr_i      D-cache block address / write data
//   d_rw_i/d_valid_i     D-cache direction / level-held request
//   d_lock_i             D-cache keeps the grant after completion while high
//   d_rd_o/d_ready_o     read data / completion pulse to D-cache
//   mem_addr_o/mem_wr_o  memory address / write data
//   mem_rw_o/mem_valid_o memory direction / request
//   mem_rd_i/mem_ready_i memory read data / completion pulse
//   timeout_err_o        sticky watchdog flag, cleared only by reset
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 28,
    parameter int unsigned BLOCK_SIZE = 256,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] i_addr_i,
    input  logic [BLOCK_SIZE-1:0] i_wr_i,
    input  logic                  i_rw_i,
    input  logic                  i_valid_i,
    output logic [BLOCK_SIZE-1:0] i_rd_o,
    output logic                  i_ready_o,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic [BLOCK_SIZE-1:0] d_wr_i,
    input  logic                  d_rw_i,
    input  logic                  d_valid_i,
    input  logic                  d_lock_i,
    output logic [BLOCK_SIZE-1:0] d_rd_o,
    output logic                  d_ready_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [BLOCK_SIZE-1:0] mem_wr_o,
    output logic                  mem_rw_o,
    output logic                  mem_valid_o,
    input  logic [BLOCK_SIZE-1:0] mem_rd_i,
    input  logic                  mem_ready_i,
    output logic                  timeout_err_o
);

    localparam int unsigned WdW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StGrantI = 2'd1,
        StGrantD = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic           last_d_q, last_d_d;  // 1: D-cache held the last completed grant
    logic [WdW-1:0] wd_q, wd_d;
    logic           err_q, err_d;
    logic           wd_expire;

    // Memory port and ready/data return are pure muxes on the grant; decoding from the
    // asynchronously reset state drops mem_valid_o as soon as rst_n falls.
    always_comb begin
        mem_addr_o  = '0;
        mem_wr_o    = '0;
        mem_rw_o    = 1'b0;
        mem_valid_o = 1'b0;
        i_ready_o   = 1'b0;
        i_rd_o      = '0;
        d_ready_o   = 1'b0;
        d_rd_o      = '0;
        unique case (state_q)
            StGrantI: begin
                mem_addr_o  = i_addr_i;
                mem_wr_o    = i_wr_i;
                mem_rw_o    = i_rw_i;
                mem_valid_o = i_valid_i;
                i_ready_o   = mem_ready_i;
                i_rd_o      = mem_rd_i;
            end
            StGrantD: begin
                mem_addr_o  = d_addr_i;
                mem_wr_o    = d_wr_i;
                mem_rw_o    = d_rw_i;
                mem_valid_o = d_valid_i;
                d_ready_o   = mem_ready_i;
                d_rd_o      = mem_rd_i;
            end
            default: ;
        endcase
    end

    // Fires in the TIMEOUT-th consecutive cycle of an unanswered request.
    assign wd_expire = mem_valid_o && !mem_ready_i && (wd_q == WdW'(TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        err_d    = err_q;

        if (state_q == StIdle || mem_ready_i || !mem_valid_o || wd_expire) begin
            wd_d = '0;
        end else begin
            wd_d = wd_q + WdW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (i_valid_i && d_valid_i) begin
                    state_d = last_d_q ? StGrantI : StGrantD;
                end else if (i_valid_i) begin
                    state_d = StGrantI;
                end else if (d_valid_i) begin
                    state_d = StGrantD;
                end
            end
            StGrantI: begin
                if (wd_expire) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else if (mem_ready_i) begin
                    last_d_d = 1'b0;
                    state_d  = StIdle;
                end else if (!i_valid_i) begin
                    // Requester withdrew: abort without a ready pulse.
                    state_d = StIdle;
                end
            end
            StGrantD: begin
                if (wd_expire) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else if (mem_ready_i) begin
                    last_d_d = 1'b1;
                    state_d  = d_lock_i ? StGrantD : StIdle;
                end else if (!d_valid_i && !d_lock_i) begin
                    // Locked with no request keeps the grant; otherwise it is an abort.
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            last_d_q <= 1'b1;
            wd_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            wd_q     <= wd_d;
            err_q    <= err_d;
        end
    end

    assign timeout_err_o = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter (TIMEOUT = 8).
module tb_mem_arbiter;

    localparam int unsigned AW = 28;
    localparam int unsigned BW = 256;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic [BW-1:0] i_wr, d_wr, i_rd, d_rd, mem_wr, mem_rd;
    logic          i_rw, i_valid, i_ready;
    logic          d_rw, d_valid, d_lock, d_ready;
    logic          mem_rw, mem_valid, mem_ready, timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [BW-1:0] data_a;
    logic [BW-1:0] data_b;
    logic [BW-1:0] data_w;

    mem_arbiter #(
        .ADDR_WIDTH(AW),
        .BLOCK_SIZE(BW),
        .TIMEOUT   (8)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_addr_i     (i_addr),
        .i_wr_i       (i_wr),
        .i_rw_i       (i_rw),
        .i_valid_i    (i_valid),
        .i_rd_o       (i_rd),
        .i_ready_o    (i_ready),
        .d_addr_i     (d_addr),
        .d_wr_i       (d_wr),
        .d_rw_i       (d_rw),
        .d_valid_i    (d_valid),
        .d_lock_i     (d_lock),
        .d_rd_o       (d_rd),
        .d_ready_o    (d_ready),
        .mem_addr_o   (mem_addr),
        .mem_wr_o     (mem_wr),
        .mem_rw_o     (mem_rw),
        .mem_valid_o  (mem_valid),
        .mem_rd_i     (mem_rd),
        .mem_ready_i  (mem_ready),
        .timeout_err_o(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [BW-1:0] got,
                            input logic [BW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        data_a  = {8{32'hCAFEF00D}};
        data_b  = {8{32'h12345678}};
        data_w  = {8{32'hDEADBEEF}};
        rst_n   = 1'b0;
        i_addr  = 28'h0000100;
        d_addr  = 28'h0000200;
        i_wr    = '0;
        d_wr    = '0;
        i_rw    = 1'b0;
        d_rw    = 1'b0;
        i_valid = 1'b0;
        d_valid = 1'b0;
        d_lock  = 1'b0;
        mem_rd  = '0;
        mem_ready = 1'b0;

        // Reset state
        #2;
        check_eq("rst_mem_valid", 256'(mem_valid), 256'(0));
        check_eq("rst_mem_addr", 256'(mem_addr), 256'(0));
        check_eq("rst_ready", 256'({i_ready, d_ready}), 256'(0));
        check_eq("rst_err", 256'(timeout_err), 256'(0));
        tick();
        rst_n = 1'b1;
        tick();

        // 1: single I-cache read
        i_valid = 1'b1;
        #1;
        check_eq("t1_latency", 256'(mem_valid), 256'(0));
        tick();
        check_eq("t1_mem_valid", 256'(mem_valid), 256'(1));
        check_eq("t1_mem_addr", 256'(mem_addr), 256'(28'h0000100));
        check_eq("t1_mem_rw", 256'(mem_rw), 256'(0));
        tick();
        tick();
        mem_ready = 1'b1;
        mem_rd    = data_a;
        #1;
        check_eq("t1_i_ready", 256'(i_ready), 256'(1));
        check_eq("t1_i_rd", i_rd, data_a);
        check_eq("t1_d_ready", 256'(d_ready), 256'(0));
        check_eq("t1_d_rd", d_rd, 256'(0));
        tick();
        i_valid   = 1'b0;
        #1;
        // Still asserted while idle: must not leak to either cache.
        check_eq("t1_idle_i_ready", 256'(i_ready), 256'(0));
        check_eq("t1_idle_d_ready", 256'(d_ready), 256'(0));
        check_eq("t1_idle_valid", 256'(mem_valid), 256'(0));
        mem_ready = 1'b0;
        tick();

        // 2: simultaneous requests after reset
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        i_valid = 1'b1;
        d_valid = 1'b1;
        tick();
        check_eq("t2_first_I", 256'(mem_addr), 256'(28'h0000100));
        mem_ready = 1'b1;
        #1;
        check_eq("t2_i_ready", 256'(i_ready), 256'(1));
        check_eq("t2_d_ready", 256'(d_ready), 256'(0));
        tick();
        i_valid   = 1'b0;
        mem_ready = 1'b0;
        #1;
        check_eq("t2_idle_gap", 256'(mem_valid), 256'(0));
        tick();
        check_eq("t2_then_D", 256'(mem_addr), 256'(28'h0000200));
        check_eq("t2_D_valid", 256'(mem_valid), 256'(1));
        mem_ready = 1'b1;
        #1;
        check_eq("t2_d_ready", 256'(d_ready), 256'(1));
        tick();
        d_valid   = 1'b0;
        mem_ready = 1'b0;
        tick();
        i_valid = 1'b1;
        d_valid = 1'b1;
        tick();
        check_eq("t2_next_tie_I", 256'(mem_addr), 256'(28'h0000100));
        mem_ready = 1'b1;
        tick();
        i_valid   = 1'b0;
        mem_ready = 1'b0;
        // last grant is now I; d_valid still pending

        // 3: locked D write then read while I waits
        d_lock = 1'b1;
        d_rw   = 1'b1;
        d_wr   = data_w;
        i_valid = 1'b1;
        tick();
        check_eq("t3_D_granted", 256'(mem_addr), 256'(28'h0000200));
        check_eq("t3_wr_rw", 256'(mem_rw), 256'(1));
        check_eq("t3_wr_data", mem_wr, data_w);
        mem_ready = 1'b1;
        #1;
        check_eq("t3_wr_ready", 256'(d_ready), 256'(1));
        tick();
        mem_ready = 1'b0;
        d_rw      = 1'b0;
        #1;
        check_eq("t3_lock_held", 256'(mem_addr), 256'(28'h0000200));
        check_eq("t3_rd_rw", 256'(mem_rw), 256'(0));
        check_eq("t3_rd_valid", 256'(mem_valid), 256'(1));
        tick();
        mem_ready = 1'b1;
        mem_rd    = data_b;
        #1;
        check_eq("t3_rd_ready", 256'(d_ready), 256'(1));
        check_eq("t3_rd_data", d_rd, data_b);
        check_eq("t3_no_i_ready", 256'(i_ready), 256'(0));
        tick();
        mem_ready = 1'b0;
        d_valid   = 1'b0;
        #1;
        check_eq("t3_idle_locked", 256'(mem_valid), 256'(0));
        tick();
        check_eq("t3_still_locked", 256'(mem_valid), 256'(0));
        d_lock = 1'b0;
        tick();
        check_eq("t3_released_idle", 256'(mem_valid), 256'(0));
        tick();
        check_eq("t3_I_after", 256'(mem_addr), 256'(28'h0000100));
        check_eq("t3_I_valid", 256'(mem_valid), 256'(1));
        mem_ready = 1'b1;
        tick();
        i_valid   = 1'b0;
        mem_ready = 1'b0;
        tick();

        // 4: I aborts, pending D granted next
        i_valid = 1'b1;
        tick();
        check_eq("t4_I_granted", 256'(mem_addr), 256'(28'h0000100));
        d_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        #1;
        check_eq("t4_abort_valid", 256'(mem_valid), 256'(0));
        tick();
        check_eq("t4_no_i_ready", 256'(i_ready), 256'(0));
        check_eq("t4_idle", 256'(mem_valid), 256'(0));
        tick();
        check_eq("t4_D_next", 256'(mem_addr), 256'(28'h0000200));
        check_eq("t4_D_valid", 256'(mem_valid), 256'(1));
        mem_ready = 1'b1;
        tick();
        d_valid   = 1'b0;
        mem_ready = 1'b0;
        tick();

        // 5: watchdog with TIMEOUT = 8
        d_valid = 1'b1;
        tick();
        check_eq("t5_valid_c1", 256'(mem_valid), 256'(1));
        for (int k = 0; k < 7; k++) tick();
        check_eq("t5_c8_valid", 256'(mem_valid), 256'(1));
        check_eq("t5_c8_no_err", 256'(timeout_err), 256'(0));
        tick();
        check_eq("t5_err", 256'(timeout_err), 256'(1));
        check_eq("t5_dropped", 256'(mem_valid), 256'(0));
        check_eq("t5_no_d_ready", 256'(d_ready), 256'(0));
        d_valid = 1'b0;
        tick();
        tick();
        check_eq("t5_err_sticky", 256'(timeout_err), 256'(1));

        // 6: asynchronous reset mid-GRANT_D
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        check_eq("t6_err_cleared", 256'(timeout_err), 256'(0));
        d_valid = 1'b1;
        tick();
        check_eq("t6_D_granted", 256'(mem_valid), 256'(1));
        mem_ready = 1'b1;
        rst_n     = 1'b0;
        #1;
        check_eq("t6_async_valid", 256'(mem_valid), 256'(0));
        check_eq("t6_async_addr", 256'(mem_addr), 256'(0));
        check_eq("t6_async_d_ready", 256'(d_ready), 256'(0));
        mem_ready = 1'b0;
        i_valid   = 1'b1;
        rst_n     = 1'b1;
        tick();
        check_eq("t6_tie_I", 256'(mem_addr), 256'(28'h0000100));
        check_eq("t6_tie_valid", 256'(mem_valid), 256'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 256-bit main-memory port between the instruction-cache and data-cache controllers.
- Each cache controller drives a level-held request (valid/rw/addr/wr) and waits for a one-cycle ready pulse.
- Arbitration is round-robin; the grant is held until the transaction completes. An optional lock lets the D-cache keep the port across back-to-back transactions (write-back followed by allocate, or a flush sweep).
- A watchdog flags a memory that never answers.

Parameters:
- ADDR_WIDTH, 28, address width of all ports
- BLOCK_SIZE, 256, data width in bits of one cache block transfer
- TIMEOUT, 1024, cycles a granted transaction may wait for mem_ready before the watchdog fires; must be >= 2

Ports:
- clk  input  1  clock
- rst_n  input  1  reset
- i_addr  input  ADDR_WIDTH  I-cache block address
- i_wr  input  BLOCK_SIZE  I-cache write data
- i_rw  input  1  I-cache direction, 1 = write
- i_valid  input  1  I-cache request, held until i_ready
- i_rd  output  BLOCK_SIZE  read data to I-cache
- i_ready  output  1  I-cache completion pulse
- d_addr  input  ADDR_WIDTH  D-cache block address
- d_wr  input  BLOCK_SIZE  D-cache write data
- d_rw  input  1  D-cache direction, 1 = write
- d_valid  input  1  D-cache request, held until d_ready
- d_lock  input  1  D-cache keeps the grant after completion while high
- d_rd  output  BLOCK_SIZE  read data to D-cache
- d_ready  output  1  D-cache completion pulse
- mem_addr  output  ADDR_WIDTH  memory address
- mem_wr  output  BLOCK_SIZE  memory write data
- mem_rw  output  1  memory direction
- mem_valid  output  1  memory request
- mem_rd  input  BLOCK_SIZE  memory read data
- mem_ready  input  1  memory completion pulse
- timeout_err  output  1  sticky watchdog flag

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- Reset values:
  - state = IDLE
  - last_grant = D, so I wins the first tie
  - wd_count = 0
  - timeout_err = 0
  - every output = 0
- States:
  - IDLE: no grant. mem_* outputs = 0; i_ready = d_ready = 0; i_rd = d_rd = 0.
  - GRANT_I: mem_addr/mem_wr/mem_rw = i_*; mem_valid = i_valid; i_ready = mem_ready; i_rd = mem_rd. All D-side outputs = 0.
  - GRANT_D: symmetric to GRANT_I, using d_*.
- IDLE transitions:
  - Only i_valid: go to GRANT_I.
  - Only d_valid: go to GRANT_D.
  - Both valid: grant the requester that is not last_grant.
  - Neither valid: stay in IDLE.
  - There is one cycle of arbitration latency: mem_valid rises in the cycle after the request is first seen in IDLE.
- GRANT_x transitions:
  - On mem_ready: update last_grant = x.
    - In GRANT_D with d_lock = 1: stay in GRANT_D.
    - Otherwise: go to IDLE.
  - x_valid = 0 without mem_ready (protocol abort): go to IDLE; no ready pulse; last_grant is unchanged.
  - Otherwise: stay.
- In GRANT_D, d_lock = 1 with d_valid = 0 keeps the grant; mem_valid = 0 while idle-locked. Lock release (d_lock = 0) with d_valid = 0 goes to IDLE on the next clock.
- mem_ready is ignored in IDLE and never reaches either ready output.
- The ready pulse and read data are combinational passthrough from memory, gated by the grant. There is no data register.
- Watchdog:
  - wd_count clears in IDLE, on mem_ready, and when mem_valid = 0.
  - Otherwise it increments while mem_valid = 1.
  - When wd_count reaches TIMEOUT-1 without mem_ready: set timeout_err = 1, force state to IDLE (grant dropped, no ready pulse), clear wd_count.
  - timeout_err clears only on reset.
- Reset mid-transaction drops mem_valid immediately, asynchronously, and returns to IDLE.

Test Plan:
1. Only i_valid = 1, i_rw = 0, i_addr = 28'h0000100 → mem_valid = 1, mem_addr = 28'h0000100 one cycle later. Memory answers mem_ready with mem_rd = {8{32'hCAFEF00D}} three cycles later → i_ready is a one-cycle pulse with i_rd equal to that data; d_ready stays 0; state returns to IDLE.
2. After reset, i_valid and d_valid rise in the same cycle → I granted first. After its mem_ready, D is granted (d_addr = 28'h0000200 on mem_addr) with no idle gap beyond one IDLE cycle. The next simultaneous request goes to I again.
3. d_lock = 1 with d_valid held across two transactions (write d_rw = 1, then read d_rw = 0) while i_valid = 1 throughout → I not granted until d_lock = 0; mem_rw follows d_rw in each transaction.
4. i_valid drops while granted, before mem_ready → arbiter returns to IDLE; no i_ready; pending d_valid granted next.
5. TIMEOUT = 8, d_valid held, mem_ready never asserted → timeout_err = 1 after 8 cycles of mem_valid; grant dropped; d_ready = 0; timeout_err stays 1 until rst_n pulses low.
6. rst_n asserted low mid-GRANT_D → mem_valid = 0 in the same cycle, before the next clk edge; all outputs 0; after release the I/D tie goes to I.
